// File: rtl/data_mem_rmw_ctrl.sv
// data_mem_rmw_ctrl: load/store front end for a word-wide synchronous RAM,
// doing read-modify-write for byte and halfword stores.
module data_mem_rmw_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sign_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [29:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr,
    output logic [31:0] mem_wdata
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RSP   = 3'd4;

    logic [2:0]  state;
    logic [31:0] addr, wdata, data, lane, load_val, merged;
    logic [3:0]  mask;
    logic        write, err, bad;

    always_comb begin
        bad = !(req_sign_mask[2:0] == 3'b001 || req_sign_mask[2:0] == 3'b011 || req_sign_mask[2:0] == 3'b111)
            || (req_sign_mask[2:0] == 3'b011 && req_addr[0])
            || (req_sign_mask[2:0] == 3'b111 && req_addr[1:0] != 2'b00);
        lane = mem_rdata >> {addr[1:0], 3'b000};
        load_val = mask[1] ? (mask[2] ? lane : {{16{mask[3] & lane[15]}}, lane[15:0]})
                           : {{24{mask[3] & lane[7]}}, lane[7:0]};
        merged = data;
        if (mask[1])
            merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        else
            merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            err       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            data      <= '0;
            mask      <= '0;
            write     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr  <= req_addr;
                    wdata <= req_wdata;
                    mask  <= req_sign_mask;
                    write <= req_write;
                    err   <= bad;
                    if (bad) rsp_rdata <= '0;
                    state <= bad ? RSP : (req_write && req_sign_mask[2:0] == 3'b111) ? WRITE : READ;
                end
                READ: state <= WAIT;
                WAIT: begin
                    data  <= mem_rdata;
                    state <= write ? WRITE : RSP;
                    if (!write) rsp_rdata <= load_val;
                end
                WRITE: begin
                    rsp_rdata <= '0;
                    state     <= RSP;
                end
                RSP: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs: strobes and address are zero outside READ/WRITE
    assign req_ready = state == IDLE;
    assign mem_rd    = state == READ;
    assign mem_wr    = state == WRITE;
    assign rsp_valid = state == RSP;
    assign rsp_err   = rsp_valid & err;
    assign mem_addr  = (mem_rd | mem_wr) ? addr[31:2] : '0;
    assign mem_wdata = mem_wr ? (mask[2] ? wdata : merged) : '0;
endmodule

// File: tb/tb_data_mem_rmw_ctrl.sv
// tb_data_mem_rmw_ctrl: directed and random load/store checks against a
// byte-array reference model of memory.
module tb_data_mem_rmw_ctrl;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_write, rsp_valid, rsp_err, mem_rd, mem_wr;
    logic [31:0] req_addr, req_wdata, rsp_rdata, mem_rdata, mem_wdata;
    logic [3:0]  req_sign_mask;
    logic [29:0] mem_addr;
    logic [31:0] ram [16];
    logic [7:0]  shadow [64];
    logic [31:0] r, w;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    data_mem_rmw_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_sign_mask(req_sign_mask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (mem_wr) ram[mem_addr[3:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int base);
        return {shadow[base + 3], shadow[base + 2], shadow[base + 1], shadow[base]};
    endfunction

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rdata_o, output logic [31:0] wdata_o);
        int n, lat, rd_cnt, wr_cnt, rsp_cnt, rd_at, wr_at, rsp_at, addr_bad;
        logic bad, got_err;
        logic [63:0] v;
        logic [31:0] exp_rd, exp_wd;
        n = m[2:0] == 3'b001 ? 1 : m[2:0] == 3'b011 ? 2 : m[2:0] == 3'b111 ? 4 : 0;
        bad = n == 0 || (int'(a[5:0]) % n) != 0;
        exp_rd = 0;
        exp_wd = 0;
        if (!bad && wr) begin
            for (int i = 0; i < n; i++) shadow[int'(a[5:0]) + i] = d[8*i +: 8];
            exp_wd = word_of(int'(a[5:0]) & ~3);
        end else if (!bad) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (64'(shadow[int'(a[5:0]) + i]) << (8 * i));
            if (m[3] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
            exp_rd = v[31:0];
        end
        lat = bad ? 1 : !wr ? 3 : n == 4 ? 2 : 4;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_sign_mask = m;
        @(posedge clk);
        #1 req_valid = 0;
        rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0; rd_at = 0; wr_at = 0; rsp_at = 0; addr_bad = 0;
        got_err = 0; rdata_o = 'x; wdata_o = 'x;
        for (int c = 1; c <= 6; c++) begin
            if (mem_rd) begin rd_cnt++; rd_at = c; end
            if (mem_wr) begin wr_cnt++; wr_at = c; wdata_o = mem_wdata; end
            if (rsp_valid) begin rsp_cnt++; rsp_at = c; got_err = rsp_err; rdata_o = rsp_rdata; end
            if (mem_addr !== ((mem_rd || mem_wr) ? a[31:2] : 30'd0) || (mem_rd && mem_wr)) addr_bad++;
            @(posedge clk);
            #1;
        end
        chk("rsp_latency", 32'(rsp_at), 32'(lat));
        chk("rsp_count", 32'(rsp_cnt), 32'd1);
        chk("rsp_err", 32'(got_err), 32'(bad));
        chk("rsp_rdata", rdata_o, exp_rd);
        chk("rsp_rdata_hold", rsp_rdata, exp_rd);
        chk("mem_rd_count", 32'(rd_cnt), 32'(!bad && !(wr && n == 4)));
        chk("mem_wr_count", 32'(wr_cnt), 32'(!bad && wr));
        chk("mem_addr", 32'(addr_bad), 32'd0);
        if (rd_cnt == 1) chk("mem_rd_at", 32'(rd_at), 32'd1);
        if (!bad && wr) begin
            chk("mem_wr_at", 32'(wr_at), n == 4 ? 32'd1 : 32'd3);
            chk("mem_wdata", wdata_o, exp_wd);
        end
    endtask

    initial begin
        int hits;
        logic [3:0] legal [6];
        legal = '{4'h1, 4'h3, 4'h7, 4'h9, 4'hB, 4'hF};
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_sign_mask = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {rsp_valid, rsp_err, mem_rd, mem_wr, 28'd0} | mem_wdata | rsp_rdata | 32'(mem_addr), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd1);
        rst = 0;

        for (int i = 0; i < 16; i++) do_req(1, 32'(i * 4), $urandom, 4'h7, r, w);

        do_req(1, 32'h10, 32'h8899AABB, 4'h7, r, w);
        do_req(0, 32'h13, 0, 4'h9, r, w);
        chk("ld_byte_sx", r, 32'hFFFFFF88);
        do_req(0, 32'h12, 0, 4'h3, r, w);
        chk("ld_half_zx", r, 32'h00008899);
        do_req(0, 32'h12, 0, 4'hB, r, w);
        chk("ld_half_sx", r, 32'hFFFF8899);
        do_req(1, 32'h11, 32'h5A, 4'h1, r, w);
        chk("st_byte_merge", w, 32'h88995ABB);
        do_req(1, 32'h10, 32'h8899AABB, 4'h7, r, w);
        do_req(1, 32'h12, 32'h1234, 4'h3, r, w);
        chk("st_half_merge", w, 32'h1234AABB);
        do_req(1, 32'h10, 32'hDEADBEEF, 4'h7, r, w);
        chk("st_word", w, 32'hDEADBEEF);
        do_req(0, 32'h11, 0, 4'h3, r, w);
        do_req(1, 32'h14, 32'h77, 4'h5, r, w);
        chk("ram_after_err", ram[5], word_of(20));

        // byte store abandoned by a reset pulse while waiting for read data
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h11; req_wdata = 32'hA5; req_sign_mask = 4'h1;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outputs", {rsp_valid, rsp_err, mem_rd, mem_wr, 28'd0} | mem_wdata | rsp_rdata | 32'(mem_addr), 32'd0);
        hits = 0;
        repeat (6) begin
            @(posedge clk);
            #1 hits += int'(mem_wr) + int'(rsp_valid);
        end
        chk("rst_no_activity", 32'(hits), 32'd0);
        chk("rst_ram_kept", ram[4], word_of(16));

        for (int i = 0; i < 80; i++)
            do_req($urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), $urandom,
                   $urandom_range(0, 4) == 0 ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 5)], r, w);

        for (int i = 0; i < 16; i++) chk("ram_final", ram[i], word_of(i * 4));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_rmw_ctrl.md
DATA_MEM_RMW_CTRL -- requirements
Module: data_mem_rmw_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 req_valid  in  1  core presents a load/store request.
REQ-004 req_ready  out  1  block accepts request this cycle.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 req_sign_mask  in  4  [2:0]: 001 byte, 011 halfword, 111 word; [3]: sign-extend load.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  32  load result, extended to 32 bits.
REQ-011 rsp_err  out  1  misaligned or illegal-size request; qualified by rsp_valid.
REQ-012 mem_addr  out  30  word address to synchronous RAM.
REQ-013 mem_rd  out  1  RAM read strobe; mem_rdata is valid the following cycle.
REQ-014 mem_rdata  in  32  RAM read word, little-endian byte lanes.
REQ-015 mem_wr  out  1  RAM full-word write strobe.
REQ-016 mem_wdata  out  32  RAM write word.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, WRITE, RSP.
REQ-018 req_ready SHALL be 1 only in IDLE; a handshake (req_valid & req_ready) SHALL latch addr, wdata, sign_mask and write.
REQ-019 From IDLE on handshake, the FSM SHALL go to RSP (with err) if the request is misaligned, to WRITE for a word store, and to READ otherwise.
REQ-020 Misaligned SHALL mean halfword with addr[0]=1, word with addr[1:0]!=0, or sign_mask[2:0] not in {001, 011, 111}.
REQ-021 READ SHALL assert mem_rd for exactly one cycle with mem_addr = latched addr[31:2], then go to WAIT.
REQ-022 WAIT SHALL capture mem_rdata, then go to RSP for a load or to WRITE for a sub-word store.
REQ-023 Load extraction: byte = lane addr[1:0]; half = lanes {addr[1]*2+1, addr[1]*2}; word = whole word.
REQ-024 Load extension: zero-extend when sign_mask[3]=0; replicate the MSB of the selected data when sign_mask[3]=1.
REQ-025 Store merge: byte stores SHALL replace only lane addr[1:0] with wdata[7:0]; half stores SHALL replace only the addressed 16-bit half with wdata[15:0]; other lanes SHALL keep their captured values.
REQ-026 WRITE SHALL assert mem_wr for exactly one cycle with mem_addr as latched; mem_wdata SHALL be the merged word for sub-word stores or wdata for word stores; next state RSP.
REQ-027 RSP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; it SHALL accept no back-pressure.
REQ-028 rsp_rdata SHALL be the extracted load value for loads and 0 for stores and errors, and SHALL hold until the next RSP.
REQ-029 rsp_err SHALL be 1 only in an RSP reached directly from IDLE for a misaligned request; errored requests SHALL issue no mem_rd or mem_wr.
REQ-030 Latency, with handshake in cycle T: load rsp_valid at T+3; sub-word store rsp_valid at T+4; word store rsp_valid at T+2; error rsp_valid at T+1.
REQ-031 mem_rd and mem_wr SHALL never be asserted in the same cycle; mem_addr SHALL be 0 when neither is asserted.
REQ-032 req_valid outside IDLE SHALL be ignored; the requester holds it until req_ready.

Reset
REQ-033 With rst=1 at an edge, the FSM SHALL enter IDLE and all outputs except req_ready SHALL be 0 (req_ready becomes 1 the following cycle, in IDLE).
REQ-034 Reset in any state SHALL abandon the request: no later mem_wr or rsp_valid for it, and the RAM SHALL not be written after the reset edge.

Verification
REQ-035 RAM word 4 = 0x8899AABB; load byte, addr 0x13, mask 1001 -> mem_rd at T+1, rsp_valid at T+3, rsp_rdata 0xFFFFFF88, rsp_err 0.
REQ-036 Same RAM; load half, addr 0x12, mask 0011 -> rsp_rdata 0x00008899; with mask 1011 -> 0xFFFF8899.
REQ-037 Same RAM; store byte 0x5A, addr 0x11 -> mem_wr at T+3 with mem_wdata 0x88995ABB, rsp_valid at T+4; store half 0x1234, addr 0x12 -> 0x1234AABB.
REQ-038 Store word 0xDEADBEEF, addr 0x10 -> no mem_rd, mem_wr at T+1 with mem_wdata 0xDEADBEEF, rsp_valid at T+2.
REQ-039 Load half at addr 0x11, and a request with mask 0101 -> rsp_valid at T+1, rsp_err 1, rsp_rdata 0, no RAM strobes.
REQ-040 Byte store with rst pulsed in WAIT -> no mem_wr, no rsp_valid, req_ready 1 one cycle after the reset edge, RAM unchanged.
